alub_operand_stage: RTL and testbench
=====================================

# alub_operand_stage

Parametrised, buffered successor to the ALU-B operand multiplexer of the multicycle datapath. Selects the ALU second operand from the B register, a programmable increment constant, a sign- or zero-extended immediate (plain or shifted left by 2), and NUM_EXT extra datapath channels. It registers the result behind a two-entry skid buffer with valid/ready handshakes on both sides. It sits between the register/immediate sources and the ALU B port, and lets the control unit issue operands without waiting on ALU stalls.

## Interface
- WIDTH, 32: operand width in bits.
- IMM_W, 16: raw immediate width; must satisfy IMM_W < WIDTH.
- NUM_EXT, 2: number of extra generic channels.
- SEL_W, 3: selector width; must satisfy 2^SEL_W >= 4+NUM_EXT.
- INC_CONST, 4: value driven on channel 1.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request carries a valid selector.
- in_ready  out  1  stage can accept a request this cycle.
- selector  in  SEL_W  channel index, sampled on accept.
- imm_signed  in  1  1 selects sign extension of imm_in, 0 selects zero extension.
- b_in  in  WIDTH  B register output (channel 0).
- imm_in  in  IMM_W  raw immediate (channels 2 and 3).
- ext_in  in  NUM_EXT*WIDTH  flattened extra channels; channel 4+k is ext_in[k*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds an operand.
- out_ready  in  1  ALU consumes the operand this cycle.
- out_data  out  WIDTH  selected operand.
- err_clr  in  1  clears sel_err (see Configuration).
- sel_err  out  1  sticky out-of-range selector flag.

## Operation
- Accept when in_valid && in_ready. Emit when out_valid && out_ready.
- Channel map:
  - 0: b_in.
  - 1: INC_CONST, truncated to WIDTH.
  - 2: ext(imm_in).
  - 3: ext(imm_in) << 2; the top 2 bits are discarded and zeros are shifted in.
  - 4..3+NUM_EXT: ext_in slices.
  - Any other value: 0.
- ext() replicates imm_in[IMM_W-1] when imm_signed = 1 and zero-fills otherwise. The extension is computed at accept time.
- The buffer has two entries: a main register driving out_data, and a skid register.
- State machine:
  - EMPTY (main empty, skid empty): on accept, load main and go to ONE.
  - ONE (main full, skid empty):
    - accept && emit: load main; stay in ONE.
    - accept && !emit: load skid; go to FULL.
    - !accept && emit: go to EMPTY.
  - FULL (main full, skid full): in_ready = 0. On emit, main <= skid and go to ONE.
- Order is strictly FIFO; no request is dropped or duplicated.
- in_ready is a registered signal equal to !FULL.
- out_data holds its value while out_valid && !out_ready.
- Inputs are sampled only on accept. Later changes to b_in, imm_in or ext_in do not affect buffered operands.

## Timing
- Reset (synchronous): state = EMPTY, out_valid = 0, out_data = 0, skid = 0, sel_err = 0, in_ready = 0 during the reset cycle. in_ready = 1 on the first cycle after reset is released.
- Latency: a request accepted at edge N appears on out_valid/out_data after edge N, i.e. 1 cycle.
- Throughput: 1 operand per cycle while out_ready stays high.
- Stall: after out_ready drops, at most one further request is accepted (into the skid). in_ready drops in the following cycle.
- FULL with emit and in_valid in the same cycle: the request is not accepted, because in_ready = 0 that cycle. in_ready returns to 1 in the next cycle.
- Reset mid-operation discards both entries regardless of handshake state.

## Configuration
- ALUB_SEL_ERR_EN defined:
  - Accepting an out-of-range selector (value >= 4+NUM_EXT) sets sel_err at the accept edge; the operand is still 0.
  - sel_err stays set until err_clr = 1 or reset.
  - If err_clr and a new error occur in the same cycle, sel_err stays set.
- ALUB_SEL_ERR_EN undefined: sel_err is tied to 0 and err_clr is ignored. Out-of-range selectors silently yield 0.

## Test plan
- Reset, then sel=1, out_ready=1 -> out_valid=1 one cycle later with out_data=0x00000004; in_ready=1 throughout.
- imm_in=0x8001, sel=2, then sel=3, with imm_signed=1 -> 0xFFFF8001, then 0xFFFE0004. Repeat with imm_signed=0 -> 0x00008001, then 0x00020004.
- Back-to-back sel=0 with b_in=0xA, then 0xB, then 0xC, holding out_ready=0 -> in_ready drops after two accepts. Raise out_ready -> outputs 0xA then 0xB in order; 0xC is accepted after in_ready returns to 1.
- FULL state, then assert reset for one cycle -> out_valid=0, out_data=0, and no stale operand is emitted afterwards.
- sel=7 with NUM_EXT=2 -> out_data=0. With ALUB_SEL_ERR_EN defined, sel_err=1 until err_clr pulses; without the macro, sel_err=0.
- sel=4 and sel=5 with ext_in={0x22222222, 0x11111111} -> 0x11111111 then 0x22222222.

Source files
------------

// File: rtl/alub_operand_stage.sv
// ALU-B operand selector with a registered two-entry skid buffer and valid/ready on both sides.
// Optional sticky out-of-range selector flag enabled by defining ALUB_SEL_ERR_EN.
module alub_operand_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_W     = 16,
  parameter int unsigned NUM_EXT   = 2,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned INC_CONST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         selector,
  input  logic                     imm_signed,
  input  logic [WIDTH-1:0]         b_in,
  input  logic [IMM_W-1:0]         imm_in,
  input  logic [NUM_EXT*WIDTH-1:0] ext_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     err_clr,
  output logic                     sel_err
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             out_valid_q, in_ready_q;
  logic [WIDTH-1:0] imm_ext, operand;
  logic             accept, emit;

  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  assign imm_ext = {{(WIDTH-IMM_W){imm_signed & imm_in[IMM_W-1]}}, imm_in};

  always_comb begin
    operand = '0;
    case (32'(selector))
      32'd0:   operand = b_in;
      32'd1:   operand = WIDTH'(INC_CONST);
      32'd2:   operand = imm_ext;
      32'd3:   operand = {imm_ext[WIDTH-3:0], 2'b00};
      default: begin
        for (int unsigned k = 0; k < NUM_EXT; k++) begin
          if (32'(selector) == 4 + k) operand = ext_in[k*WIDTH +: WIDTH];
        end
      end
    endcase
  end

  // in_ready is registered, so it is computed here from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      in_ready_q <= 1'b1;
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q      <= operand;
            out_valid_q <= 1'b1;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (accept && emit) begin
            main_q <= operand;
          end else if (accept) begin
            skid_q     <= operand;
            in_ready_q <= 1'b0;
            state_q    <= StFull;
          end else if (emit) begin
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end
        end
        StFull: begin
          if (emit) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StEmpty;
        end
      endcase
    end
  end

`ifdef ALUB_SEL_ERR_EN
  logic sel_err_q;

  // A new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else if (accept && (32'(selector) >= 4 + NUM_EXT)) begin
      sel_err_q <= 1'b1;
    end else if (err_clr) begin
      sel_err_q <= 1'b0;
    end
  end

  assign sel_err = sel_err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign sel_err        = 1'b0;
`endif

endmodule

// File: tb/tb_alub_operand_stage.sv
// Self-checking bench for alub_operand_stage: vector table, handshake corner sequences and
// randomized traffic against a queue-based reference model.
module tb_alub_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  selector;
  logic        imm_signed;
  logic [31:0] b_in;
  logic [15:0] imm_in;
  logic [63:0] ext_in;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        err_clr, sel_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alub_operand_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .selector   (selector),
    .imm_signed (imm_signed),
    .b_in       (b_in),
    .imm_in     (imm_in),
    .ext_in     (ext_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err_clr    (err_clr),
    .sel_err    (sel_err)
  );

  typedef struct {
    logic [2:0]  sel;
    logic        sgn;
    logic [31:0] b;
    logic [15:0] imm;
    logic [63:0] ext;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: channel value from plain integer arithmetic.
  function automatic logic [31:0] ref_op(input int sel, input bit sgn, input logic [31:0] b,
                                         input logic [15:0] imm, input logic [63:0] ext);
    longint v;
    longint v4;
    v = longint'(imm);
    if (sgn && imm >= 16'h8000) v = v - 65536;
    v4 = v * 4;
    case (sel)
      0:       return b;
      1:       return 32'd4;
      2:       return v[31:0];
      3:       return v4[31:0];
      4:       return ext[31:0];
      5:       return ext[63:32];
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] q[$];
  bit          ready_m;
  bit          err_m;
  bit          acc, emt;
  logic        exp_err;

  initial begin
    vecs[0] = '{3'd1, 1'b0, 32'h0,        16'h0,    64'h0, 32'h0000_0004};
    vecs[1] = '{3'd2, 1'b1, 32'h0,        16'h8001, 64'h0, 32'hFFFF_8001};
    vecs[2] = '{3'd3, 1'b1, 32'h0,        16'h8001, 64'h0, 32'hFFFE_0004};
    vecs[3] = '{3'd2, 1'b0, 32'h0,        16'h8001, 64'h0, 32'h0000_8001};
    vecs[4] = '{3'd3, 1'b0, 32'h0,        16'h8001, 64'h0, 32'h0002_0004};
    vecs[5] = '{3'd2, 1'b1, 32'h0,        16'h7FFF, 64'h0, 32'h0000_7FFF};
    vecs[6] = '{3'd0, 1'b0, 32'h1234_5678, 16'h0,   64'h0, 32'h1234_5678};
    vecs[7] = '{3'd4, 1'b0, 32'h0,        16'h0,    64'h2222_2222_1111_1111, 32'h1111_1111};
    vecs[8] = '{3'd5, 1'b0, 32'h0,        16'h0,    64'h2222_2222_1111_1111, 32'h2222_2222};
    vecs[9] = '{3'd7, 1'b0, 32'hDEAD_BEEF, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0};

    reset = 1'b1; in_valid = 1'b0; selector = '0; imm_signed = 1'b0; b_in = '0;
    imm_in = '0; ext_in = '0; out_ready = 1'b1; err_clr = 1'b0;
    step();
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_sel_err", 32'(sel_err), 32'd0);
    reset = 1'b0;
    step();
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Single-request vectors: one cycle of latency, drained the following cycle.
    for (int i = 0; i < 10; i++) begin
      selector = vecs[i].sel; imm_signed = vecs[i].sgn; b_in = vecs[i].b;
      imm_in = vecs[i].imm; ext_in = vecs[i].ext; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
    end

`ifdef ALUB_SEL_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    chk("sel_err_sticky", 32'(sel_err), 32'(exp_err));
    step();
    chk("sel_err_held", 32'(sel_err), 32'(exp_err));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("sel_err_cleared", 32'(sel_err), 32'd0);
    // Clear and new error in the same cycle: error wins.
    selector = 3'd6; in_valid = 1'b1; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("sel6_data", out_data, 32'd0);
    chk("sel_err_clr_collide", 32'(sel_err), 32'(exp_err));
    step();

    // Backpressure: two accepts fill the buffer, third waits for in_ready.
    out_ready = 1'b0; selector = 3'd0; in_valid = 1'b1; b_in = 32'hA;
    step();
    chk("bp_first_data", out_data, 32'hA);
    chk("bp_first_ready", 32'(in_ready), 32'd1);
    b_in = 32'hB;
    step();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_data", out_data, 32'hA);
    b_in = 32'hC;
    step();
    chk("bp_hold_data", out_data, 32'hA);
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_second_data", out_data, 32'hB);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("bp_third_data", out_data, 32'hC);
    chk("bp_third_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset while FULL discards both entries.
    out_ready = 1'b0; in_valid = 1'b1; b_in = 32'h55;
    step();
    b_in = 32'h66;
    step();
    chk("full_before_reset", 32'(in_ready), 32'd0);
    in_valid = 1'b0; reset = 1'b1;
    step();
    chk("rst_full_valid", 32'(out_valid), 32'd0);
    chk("rst_full_data", out_data, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    step();
    chk("rst_full_no_stale", 32'(out_valid), 32'd0);
    chk("rst_full_ready", 32'(in_ready), 32'd1);
    step();
    chk("rst_full_no_stale2", 32'(out_valid), 32'd0);

    // Randomized traffic against the queue model.
    reset = 1'b1;
    step();
    q.delete(); ready_m = 1'b0; err_m = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      in_valid   = $urandom_range(0, 1) == 1;
      selector   = 3'($urandom_range(0, 7));
      imm_signed = $urandom_range(0, 1) == 1;
      b_in       = $urandom;
      imm_in     = 16'($urandom);
      ext_in     = {$urandom, $urandom};
      out_ready  = ($urandom_range(0, 3) != 0);
      err_clr    = ($urandom_range(0, 7) == 0);
      if (reset) begin
        q.delete(); ready_m = 1'b0; err_m = 1'b0;
      end else begin
        acc = in_valid && ready_m;
        emt = (q.size() > 0) && out_ready;
        if (emt) void'(q.pop_front());
        if (acc) q.push_back(ref_op(int'(selector), imm_signed, b_in, imm_in, ext_in));
`ifdef ALUB_SEL_ERR_EN
        if (acc && selector >= 3'd6) err_m = 1'b1;
        else if (err_clr) err_m = 1'b0;
`endif
        ready_m = (q.size() < 2);
      end
      step();
      chk("rand_in_ready", 32'(in_ready), 32'(ready_m));
      chk("rand_out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("rand_out_data", out_data, q[0]);
      if (reset) chk("rand_reset_data", out_data, 32'd0);
      chk("rand_sel_err", 32'(sel_err), 32'(err_m));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
